rbfu_sched: RTL and testbench
=============================

Name: rbfu_sched

Overview:
- Sequences one shared RBFU through a complete NTT, INTT or PWM over an N-point coefficient buffer.
- Generates per-operation read addresses, the RBFU control (opcode, radix_mode), and pass and twiddle-group indices for the twiddle ROM.
- Tracks the RBFU's fixed pipeline latency so it can emit write-back addresses aligned with Dout0..3.
- Drains the pipeline between passes to avoid read-after-write hazards. Sits between the top-level control FSM and the coefficient-bank arbiter.

Parameters:
- LOG2N, 8, log2 of polynomial length N (N=256).
- NUM_R2_LAYERS, 7, radix-2 layers of the full transform. Passes = NUM_R2_LAYERS/2 radix-4 passes, plus one radix-2 pass if the count is odd.
- LAT_R2, 1, RBFU latency for radix-2 NTT/INTT, in cycles.
- LAT_R4_NTT, 2, RBFU latency for radix-4 NTT.
- LAT_R4_INTT, 3, RBFU latency for radix-4 INTT.
- LAT_PWM, 2, RBFU latency for PWM.
- MAX_LAT, 4, depth of the write-back delay line. Must be ≥ every LAT_*.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- op_in  in  2  requested operation: 00 NTT, 01 INTT, 10 PWM.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- iss_valid  out  1  an RBFU operation is presented this cycle.
- iss_ready  in  1  bank arbiter grants the reads; an op issues on iss_valid && iss_ready.
- rd_addr0..3  out  LOG2N each  addresses for rbfu_a0, b0, a1, b1.
- rbfu_opcode  out  2  to RBFU opcode.
- radix_mode  out  1  to RBFU; 1 = radix-4.
- pass_idx  out  3  current pass number.
- tw_grp  out  LOG2N  twiddle group index within the pass.
- wb_valid  out  1  Dout0..3 valid this cycle.
- wb_addr0..3  out  LOG2N each  write addresses for Dout0..3.
- wb_mask  out  4  per-lane write enable.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and delay line cleared. A reset mid-transform aborts it with no further wb_valid and no done.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE when start is high and op_in ≠ 11. op_in is latched; pass=0, c=0.
  - start with op_in=11 is ignored.
  - start while busy is ignored.
- ISSUE:
  - iss_valid=1.
  - c increments on each accepted op.
  - On acceptance of the last op (c = OPS-1) → DRAIN.
  - iss_ready low inserts a bubble; addresses hold stable.
- DRAIN:
  - iss_valid=0.
  - Stays while any op is in flight.
  - On the cycle the final wb_valid of the pass occurs → ISSUE for the next pass (c=0), or → DONE after the last pass.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Pass schedule for NTT (Cooley-Tukey):
  - Radix-4 passes with quarter stride q = N/4, N/16, … (64, 16, 4 for the defaults).
  - Then, if the layer count is odd, one radix-2 pass with h = q_last/2 (2).
- Pass schedule for INTT: the reverse order (radix-2 h=2 first, then radix-4 q=4, 16, 64).
- PWM: a single pass, radix_mode=1.
- OPS per pass is N/4 for radix-4 and radix-2, and N/2 for PWM.
- Radix-4 addressing: base = (c>>log2 q)·4q + (c mod q); rd_addr_m = base + m·q.
- Radix-2 addressing:
  - Butterflies bf0=2c and bf1=2c+1; p(bf) = (bf>>log2 h)·2h + (bf mod h).
  - rd_addr0=p(bf0), rd_addr1=p(bf0)+h, rd_addr2=p(bf1), rd_addr3=p(bf1)+h.
- PWM addressing: rd_addr0=rd_addr1=2c, rd_addr2=rd_addr3=2c+1 (f and g banks); tw_grp=c.
- tw_grp is base>>log2(4q) for radix-4 and bf0>>log2(2h) for radix-2.
- All address arithmetic uses shifts and masks, modulo N.
- Latency is fixed per pass and selected from op and radix. An op accepted at cycle t produces wb_valid at t+LAT, with its write addresses and mask delayed through the MAX_LAT delay line.
- wb_addr equals the op's rd_addr for NTT and INTT.
- wb_mask is 1111 for NTT/INTT. For PWM, wb_mask=0011, wb_addr0=2c, wb_addr1=2c+1.
- Write-back is never back-pressured.
- Each pass's period is OPS + LAT cycles with no stalls.

Decomposition:
- Shared package holds:
  - opcode constants (NTT/INTT/PWM);
  - FSM state encoding;
  - the latency defaults.
- One sub-module, rbfu_addr_gen: combinational address, tw_grp and mask generator from (op, radix, stride log, c).

Test Plan:
- NTT, iss_ready=1, start at cycle 0:
  - c=0 → rd 0,64,128,192; c=1 → 1,65,129,193.
  - Pass 2 (q=4), c=5 → 17,21,25,29.
  - Final radix-2 pass: c=0 → 0,2,1,3; c=1 → 4,6,5,7.
  - done in cycle 264.
- INTT: first pass radix_mode=0 with h=2; last pass q=64. wb_valid trails iss by 3 in radix-4 passes. No new-pass issue before the previous pass's last wb_valid.
- PWM, c=3 → rd 6,6,7,7; wb 6,7 with mask 0011; tw_grp=3; 128 ops total.
- Random iss_ready toggling → identical address/wb sequence, stretched. Each wb_valid exactly LAT after its acceptance.
- rst_n low mid-pass → all outputs 0 immediately. A subsequent start runs a clean transform from pass 0.
- start during busy, and start with op_in=11 → ignored; no busy change.

Source files
------------

// File: rtl/rbfu_sched_pkg.sv
// Shared definitions for the RBFU pass scheduler: opcodes, FSM encoding and
// default transform/latency parameters.
package rbfu_sched_pkg;

  localparam int DEF_LOG2N         = 8;
  localparam int DEF_NUM_R2_LAYERS = 7;
  localparam int DEF_LAT_R2        = 1;
  localparam int DEF_LAT_R4_NTT    = 2;
  localparam int DEF_LAT_R4_INTT   = 3;
  localparam int DEF_LAT_PWM       = 2;
  localparam int DEF_MAX_LAT       = 4;

  localparam logic [1:0] OP_NTT  = 2'b00;
  localparam logic [1:0] OP_INTT = 2'b01;
  localparam logic [1:0] OP_PWM  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rbfu_sched_addr_gen.sv
// Combinational read/write-back address, twiddle group and lane mask for one
// RBFU op, given the operation, radix and log2 of the pass stride.
module rbfu_addr_gen
  import rbfu_sched_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int SLW   = $clog2(LOG2N + 1)
) (
  input  logic [1:0]            op,
  input  logic                  radix,
  input  logic [SLW-1:0]        slog,
  input  logic [LOG2N-1:0]      c,
  output logic [3:0][LOG2N-1:0] rd_addr,
  output logic [3:0][LOG2N-1:0] wb_addr,
  output logic [3:0]            wb_mask,
  output logic [LOG2N-1:0]      tw_grp
);

  localparam logic [LOG2N-1:0] ONE = LOG2N'(1);

  logic [LOG2N-1:0] q, qm, base, bf0, bf1, p0, p1;

  always_comb begin
    q    = ONE << slog;
    qm   = q - ONE;
    base = ((c >> slog) << (slog + SLW'(2))) | (c & qm);
    bf0  = c << 1;
    bf1  = bf0 | ONE;
    p0   = ((bf0 >> slog) << (slog + SLW'(1))) | (bf0 & qm);
    p1   = ((bf1 >> slog) << (slog + SLW'(1))) | (bf1 & qm);

    rd_addr = '0;
    wb_addr = '0;
    wb_mask = 4'b1111;
    tw_grp  = '0;
    if (op == OP_PWM) begin
      // lanes 0/1 read f[2c], g[2c]; lanes 2/3 read f[2c+1], g[2c+1]
      rd_addr = {bf1, bf1, bf0, bf0};
      wb_addr = {{LOG2N{1'b0}}, {LOG2N{1'b0}}, bf1, bf0};
      wb_mask = 4'b0011;
      tw_grp  = c;
    end else if (radix) begin
      rd_addr = {base + q + (q << 1), base + (q << 1), base + q, base};
      wb_addr = rd_addr;
      tw_grp  = base >> (slog + SLW'(2));
    end else begin
      rd_addr = {p1 + q, p1, p0 + q, p0};
      wb_addr = rd_addr;
      tw_grp  = bf0 >> (slog + SLW'(1));
    end
  end

endmodule

// File: rtl/rbfu_sched.sv
// Pass scheduler for one shared RBFU: issues NTT/INTT/PWM ops pass by pass,
// drains the pipeline between passes and delays write-back addresses by LAT.
//   state   | meaning
//   IDLE    | waiting for start with a valid op
//   ISSUE   | presenting ops, c advances on iss_ready
//   DRAIN   | pass issued, waiting for its last write-back
//   DONE    | one-cycle completion pulse
module rbfu_sched
  import rbfu_sched_pkg::*;
#(
  parameter int LOG2N         = DEF_LOG2N,
  parameter int NUM_R2_LAYERS = DEF_NUM_R2_LAYERS,
  parameter int LAT_R2        = DEF_LAT_R2,
  parameter int LAT_R4_NTT    = DEF_LAT_R4_NTT,
  parameter int LAT_R4_INTT   = DEF_LAT_R4_INTT,
  parameter int LAT_PWM       = DEF_LAT_PWM,
  parameter int MAX_LAT       = DEF_MAX_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_in,
  output logic             busy,
  output logic             done,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-1:0] rd_addr2,
  output logic [LOG2N-1:0] rd_addr3,
  output logic [1:0]       rbfu_opcode,
  output logic             radix_mode,
  output logic [2:0]       pass_idx,
  output logic [LOG2N-1:0] tw_grp,
  output logic             wb_valid,
  output logic [LOG2N-1:0] wb_addr0,
  output logic [LOG2N-1:0] wb_addr1,
  output logic [LOG2N-1:0] wb_addr2,
  output logic [LOG2N-1:0] wb_addr3,
  output logic [3:0]       wb_mask
);

  localparam int N     = 1 << LOG2N;
  localparam int N_R4  = NUM_R2_LAYERS / 2;
  localparam int NPASS = N_R4 + NUM_R2_LAYERS % 2;
  localparam int SLW   = $clog2(LOG2N + 1);
  localparam int LW    = $clog2(MAX_LAT + 1);
  localparam int TW    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t                state;
  logic [1:0]            op_q;
  logic [2:0]            pass, sched_p;
  logic [LOG2N-1:0]      c, last_c;
  logic [LW-1:0]         lat, dcnt;
  logic [SLW-1:0]        slog;
  logic                  radix, last_pass, accept;
  logic [TW-1:0]         tap;
  logic [3:0][LOG2N-1:0] gen_rd, gen_wb;
  logic [3:0]            gen_mask;
  logic [LOG2N-1:0]      gen_tw;
  logic [MAX_LAT-1:0]    dl_vld;
  logic [3:0][LOG2N-1:0] dl_addr [MAX_LAT];
  logic [3:0]            dl_mask [MAX_LAT];

  // INTT walks the NTT pass list backwards
  always_comb begin
    sched_p   = (op_q == OP_INTT) ? 3'(NPASS - 1 - int'(pass)) : pass;
    radix     = 1'b1;
    slog      = '0;
    lat       = LW'(LAT_PWM);
    last_c    = LOG2N'(N / 2 - 1);
    if (op_q != OP_PWM) begin
      last_c = LOG2N'(N / 4 - 1);
      if (int'(sched_p) < N_R4) begin
        slog = SLW'(LOG2N - 2 - 2 * int'(sched_p));
        lat  = (op_q == OP_INTT) ? LW'(LAT_R4_INTT) : LW'(LAT_R4_NTT);
      end else begin
        radix = 1'b0;
        slog  = SLW'(LOG2N - 2 * N_R4 - 1);
        lat   = LW'(LAT_R2);
      end
    end
    last_pass = (op_q == OP_PWM) || (int'(pass) == NPASS - 1);
    tap       = TW'(lat - LW'(1));
    accept    = iss_valid && iss_ready;
  end

  rbfu_addr_gen #(.LOG2N(LOG2N), .SLW(SLW)) u_addr_gen (
    .op      (op_q),
    .radix   (radix),
    .slog    (slog),
    .c       (c),
    .rd_addr (gen_rd),
    .wb_addr (gen_wb),
    .wb_mask (gen_mask),
    .tw_grp  (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      pass      <= '0;
      c         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      iss_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && op_in != 2'b11) begin
            op_q      <= op_in;
            pass      <= '0;
            c         <= '0;
            busy      <= 1'b1;
            iss_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (c == last_c) begin
              iss_valid <= 1'b0;
              dcnt      <= lat - LW'(1);
              state     <= S_DRAIN;
            end else begin
              c <= c + LOG2N'(1);
            end
          end
        end
        S_DRAIN: begin
          // dcnt hits zero on the cycle the pass's last write-back is presented
          if (dcnt == '0) begin
            if (last_pass) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pass      <= pass + 3'd1;
              c         <= '0;
              iss_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          end else begin
            dcnt <= dcnt - LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // valid bits never travel past the current tap, so a longer next-pass
  // latency cannot pick up stale entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < MAX_LAT; i++) begin
        dl_addr[i] <= '0;
        dl_mask[i] <= '0;
      end
    end else begin
      dl_vld[0]  <= accept;
      dl_addr[0] <= gen_wb;
      dl_mask[0] <= gen_mask;
      for (int i = 1; i < MAX_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1] && (i < int'(lat));
        dl_addr[i] <= dl_addr[i-1];
        dl_mask[i] <= dl_mask[i-1];
      end
    end
  end

  always_comb begin
    rd_addr0    = iss_valid ? gen_rd[0] : '0;
    rd_addr1    = iss_valid ? gen_rd[1] : '0;
    rd_addr2    = iss_valid ? gen_rd[2] : '0;
    rd_addr3    = iss_valid ? gen_rd[3] : '0;
    tw_grp      = iss_valid ? gen_tw : '0;
    rbfu_opcode = busy ? op_q : 2'b00;
    radix_mode  = busy && radix;
    pass_idx    = busy ? pass : 3'd0;
    wb_valid    = dl_vld[tap];
    wb_addr0    = wb_valid ? dl_addr[tap][0] : '0;
    wb_addr1    = wb_valid ? dl_addr[tap][1] : '0;
    wb_addr2    = wb_valid ? dl_addr[tap][2] : '0;
    wb_addr3    = wb_valid ? dl_addr[tap][3] : '0;
    wb_mask     = wb_valid ? dl_mask[tap] : 4'b0000;
  end

endmodule

// File: tb/tb_rbfu_sched.sv
// Self-checking bench for rbfu_sched: an op-list reference model built from
// the pass/stride rules is compared against issue and write-back traffic.
module tb_rbfu_sched;

  localparam logic [1:0] OP_NTT  = 2'b00;
  localparam logic [1:0] OP_INTT = 2'b01;
  localparam logic [1:0] OP_PWM  = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic       iss_ready = 1'b0;
  logic       busy, done, iss_valid, radix_mode, wb_valid;
  logic [7:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_grp;
  logic [7:0] wb_addr0, wb_addr1, wb_addr2, wb_addr3;
  logic [1:0] rbfu_opcode;
  logic [2:0] pass_idx;
  logic [3:0] wb_mask;

  rbfu_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in),
    .busy(busy), .done(done), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rbfu_opcode(rbfu_opcode), .radix_mode(radix_mode), .pass_idx(pass_idx),
    .tw_grp(tw_grp), .wb_valid(wb_valid),
    .wb_addr0(wb_addr0), .wb_addr1(wb_addr1), .wb_addr2(wb_addr2), .wb_addr3(wb_addr3),
    .wb_mask(wb_mask)
  );

  always #5 clk = ~clk;

  wire [85:0] all_out = {busy, done, iss_valid, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
                         rbfu_opcode, radix_mode, pass_idx, tw_grp, wb_valid,
                         wb_addr0, wb_addr1, wb_addr2, wb_addr3, wb_mask};

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wb;
    logic [3:0]  mask;
    logic [7:0]  tw;
    logic        rad;
    logic [2:0]  pidx;
    int          lat;
    bit          first;
  } op_t;

  op_t exp_q[$];
  op_t fly_q[$];
  int  due_q[$];
  int  exp_done, last_done, last_ops;
  int  n_checks = 0;
  int  n_pass = 0;

  function automatic int pos(input int b, input int h);
    return (b / h) * 2 * h + b % h;
  endfunction

  task automatic build_model(input logic [1:0] op);
    op_t e;
    int  sp, s, lat, base, p0, p1;
    bit  r4;
    exp_q.delete();
    exp_done = 1;
    if (op == OP_PWM) begin
      for (int c = 0; c < 128; c++) begin
        e.rd = {8'(2*c), 8'(2*c), 8'(2*c+1), 8'(2*c+1)};
        e.wb = {8'(2*c), 8'(2*c+1), 16'h0000};
        e.mask = 4'b0011; e.tw = 8'(c); e.rad = 1'b1; e.pidx = 3'd0;
        e.lat = 2; e.first = (c == 0);
        exp_q.push_back(e);
      end
      exp_done += 128 + 2;
    end else begin
      for (int p = 0; p < 4; p++) begin
        sp  = (op == OP_INTT) ? 3 - p : p;
        r4  = (sp < 3);
        s   = r4 ? 256 / (4 ** (sp + 1)) : 2;
        lat = r4 ? ((op == OP_INTT) ? 3 : 2) : 1;
        for (int c = 0; c < 64; c++) begin
          if (r4) begin
            base = (c / s) * 4 * s + c % s;
            e.rd = {8'(base), 8'(base + s), 8'(base + 2*s), 8'(base + 3*s)};
            e.tw = 8'(base / (4 * s));
          end else begin
            p0 = pos(2*c, s);
            p1 = pos(2*c + 1, s);
            e.rd = {8'(p0), 8'(p0 + s), 8'(p1), 8'(p1 + s)};
            e.tw = 8'((2*c) / (2 * s));
          end
          e.wb = e.rd; e.mask = 4'b1111; e.rad = r4; e.pidx = 3'(p);
          e.lat = lat; e.first = (c == 0);
          exp_q.push_back(e);
        end
        exp_done += 64 + lat;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input bit rnd, input int poke);
    op_t         e, f;
    int          k, due;
    bit          finished;
    logic [31:0] cmp;
    build_model(op);
    fly_q.delete(); due_q.delete();
    last_ops = 0; last_done = -1;
    @(posedge clk); #1; start = 1'b1; op_in = op; iss_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 1; finished = 1'b0;
    while (!finished && k < 4000) begin
      start = (k == poke);
      if (k == poke) op_in = (op == OP_PWM) ? OP_NTT : OP_PWM;
      iss_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n_checks++;
      if (done) begin
        if (busy === 1'b0) n_pass++;
        else $display("FAIL done_busy cycle %0d busy=%b want 0", k, busy);
        n_checks++;
        if (exp_q.size() == 0 && fly_q.size() == 0) n_pass++;
        else $display("FAIL done_drained cycle %0d left=%0d inflight=%0d want 0/0", k, exp_q.size(), fly_q.size());
        last_done = k; finished = 1'b1;
      end else begin
        if (busy === 1'b1) n_pass++;
        else $display("FAIL busy cycle %0d busy=%b want 1", k, busy);
      end
      if (iss_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_issue cycle %0d rd=%h want none", k, {rd_addr0, rd_addr1, rd_addr2, rd_addr3});
        end else begin
          n_pass++;
          e = exp_q[0];
          if (e.first) begin
            n_checks++;
            if (fly_q.size() == 0) n_pass++;
            else $display("FAIL pass_hazard cycle %0d inflight=%0d want 0", k, fly_q.size());
          end
          n_checks++;
          if ({rd_addr0, rd_addr1, rd_addr2, rd_addr3} === e.rd) n_pass++;
          else $display("FAIL rd_addr cycle %0d got %h want %h", k, {rd_addr0, rd_addr1, rd_addr2, rd_addr3}, e.rd);
          n_checks++;
          if ({rbfu_opcode, radix_mode, pass_idx, tw_grp} === {op, e.rad, e.pidx, e.tw}) n_pass++;
          else $display("FAIL ctl cycle %0d got op=%0d rad=%b pass=%0d tw=%0d want op=%0d rad=%b pass=%0d tw=%0d",
                        k, rbfu_opcode, radix_mode, pass_idx, tw_grp, op, e.rad, e.pidx, e.tw);
          if (iss_ready) begin
            void'(exp_q.pop_front());
            fly_q.push_back(e);
            due_q.push_back(k + e.lat);
            last_ops++;
          end
        end
      end
      if (wb_valid === 1'b1) begin
        n_checks++;
        if (fly_q.size() == 0) begin
          $display("FAIL extra_wb cycle %0d wb=%h want none", k, {wb_addr0, wb_addr1, wb_addr2, wb_addr3});
        end else begin
          n_pass++;
          f = fly_q.pop_front();
          due = due_q.pop_front();
          cmp = (f.mask == 4'b0011) ? 32'hFFFF0000 : 32'hFFFFFFFF;
          n_checks++;
          if (k == due) n_pass++;
          else $display("FAIL wb_cycle got %0d want %0d", k, due);
          n_checks++;
          if (({wb_addr0, wb_addr1, wb_addr2, wb_addr3} & cmp) === (f.wb & cmp)) n_pass++;
          else $display("FAIL wb_addr cycle %0d got %h want %h", k, {wb_addr0, wb_addr1, wb_addr2, wb_addr3} & cmp, f.wb & cmp);
          n_checks++;
          if (wb_mask === f.mask) n_pass++;
          else $display("FAIL wb_mask cycle %0d got %b want %b", k, wb_mask, f.mask);
        end
      end
      @(posedge clk); #1; k++;
    end
    start = 1'b0;
    n_checks++;
    if (finished) n_pass++;
    else $display("FAIL timeout op=%0d got no done within %0d cycles want done", op, k);
    @(negedge clk);
    n_checks++;
    if (done === 1'b0 && busy === 1'b0) n_pass++;
    else $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (all_out === '0) n_pass++;
    else $display("FAIL reset_outputs got %h want 0", all_out);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_out === '0) n_pass++;
    else $display("FAIL post_reset_outputs got %h want 0", all_out);
  endtask

  task automatic test_ntt;
    run_op(OP_NTT, 1'b0, -1);
    n_checks++;
    if (last_done == 264 && last_done == exp_done) n_pass++;
    else $display("FAIL ntt_done_cycle got %0d want 264", last_done);
    n_checks++;
    if (last_ops == 256) n_pass++;
    else $display("FAIL ntt_ops got %0d want 256", last_ops);
  endtask

  task automatic test_intt;
    run_op(OP_INTT, 1'b0, -1);
    n_checks++;
    if (last_done == 267) n_pass++;
    else $display("FAIL intt_done_cycle got %0d want 267", last_done);
  endtask

  task automatic test_pwm;
    run_op(OP_PWM, 1'b0, -1);
    n_checks++;
    if (last_ops == 128) n_pass++;
    else $display("FAIL pwm_ops got %0d want 128", last_ops);
    n_checks++;
    if (last_done == 131) n_pass++;
    else $display("FAIL pwm_done_cycle got %0d want 131", last_done);
  endtask

  task automatic test_random_ready;
    run_op(OP_INTT, 1'b1, 40);
    n_checks++;
    if (last_ops == 256) n_pass++;
    else $display("FAIL rnd_intt_ops got %0d want 256", last_ops);
    run_op(OP_NTT, 1'b1, -1);
    run_op(OP_PWM, 1'b1, 7);
    n_checks++;
    if (last_ops == 128) n_pass++;
    else $display("FAIL rnd_pwm_ops got %0d want 128", last_ops);
  endtask

  task automatic test_ignored_start;
    @(posedge clk); #1; start = 1'b1; op_in = 2'b11; iss_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0; op_in = OP_NTT;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, iss_valid, done} === 3'b000) n_pass++;
      else $display("FAIL op11_ignored busy/iss/done=%b want 000", {busy, iss_valid, done});
    end
  endtask

  task automatic test_abort;
    @(posedge clk); #1; start = 1'b1; op_in = OP_INTT; iss_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (150) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_out === '0) n_pass++;
    else $display("FAIL abort_outputs got %h want 0", all_out);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, wb_valid, done} === 3'b000) n_pass++;
      else $display("FAIL abort_quiet busy/wb/done=%b want 000", {busy, wb_valid, done});
    end
    run_op(OP_NTT, 1'b0, -1);
    n_checks++;
    if (last_done == 264) n_pass++;
    else $display("FAIL rerun_done_cycle got %0d want 264", last_done);
  endtask

  initial begin
    test_reset;
    test_ntt;
    test_intt;
    test_pwm;
    test_random_ready;
    test_ignored_start;
    test_abort;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
